// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked ALU. Eight single-cycle ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// One operation in flight; results held on the output until consumed.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | iterating a multiply/divide
// DONE  | result valid, waiting for out_ready
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               overflow_q, overflow_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               negative_q, negative_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q, acc_d;        // {high/remainder, low/quotient}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;        // 0 MUL, 1 MULHU, 2 DIVU, 3 REMU

  logic [WIDTH-1:0]   sc_y;
  logic               sc_c, sc_o;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [CNT_W-1:0]   shamt;
  logic               is_mc;
  logic [2*WIDTH-1:0] step;
  logic               res_wr;

  // Shift-add step: add multiplicand into the high half when the low bit is set,
  // then shift the whole accumulator right (the carry lands in the top bit).
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, acc[WIDTH-1:1]};
  endfunction

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. With divisor 0 this naturally yields an
  // all-ones quotient and a remainder equal to the dividend.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] rem;
    sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge  = (sh >= {1'b0, d});
    rem = ge ? (sh[WIDTH-1:0] - d) : sh[WIDTH-1:0];
    return {rem, acc[WIDTH-2:0], ge};
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign overflow  = overflow_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign is_mc     = (op[3:2] == 2'b10);

  // Single-cycle result and flags straight from the input operands.
  always_comb begin
    sc_y   = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    shamt  = (b >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH - 1) : b[CNT_W-1:0];
    case (op)
      OP_ADD: begin
        sc_y = sum_w[WIDTH-1:0];
        sc_c = sum_w[WIDTH];
        sc_o = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_y = diff_w[WIDTH-1:0];
        sc_c = diff_w[WIDTH];
        sc_o = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_y = a & b;
      OP_OR:   sc_y = a | b;
      OP_XOR:  sc_y = a ^ b;
      OP_SLL:  sc_y = a << shamt;
      OP_SRL:  sc_y = a >> shamt;
      OP_SRA:  sc_y = $signed(a) >>> shamt;
      default: sc_y = '0;
    endcase
  end

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    overflow_d = overflow_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    res_wr     = 1'b0;
    step       = sel_q[1] ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mc) begin
            // The accept edge already performs the first iteration so that
            // the result is visible WIDTH cycles after accept.
            sel_d   = op[1:0];
            opnd_d  = op[1] ? b : a;
            acc_d   = op[1] ? div_step({{WIDTH{1'b0}}, a}, b)
                            : mul_step({{WIDTH{1'b0}}, b}, a);
            cnt_d   = CNT_W'(1);
            state_d = S_BUSY;
          end else begin
            y_d        = sc_y;
            carry_d    = sc_c;
            overflow_d = sc_o;
            res_wr     = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          res_wr     = 1'b1;
          state_d    = S_DONE;
          case (sel_q)
            2'd0: begin
              y_d     = step[WIDTH-1:0];
              carry_d = |step[2*WIDTH-1:WIDTH];
            end
            2'd1: y_d = step[2*WIDTH-1:WIDTH];
            2'd2: begin
              y_d        = step[WIDTH-1:0];
              overflow_d = (opnd_q == '0);
            end
            default: begin
              y_d        = step[2*WIDTH-1:WIDTH];
              overflow_d = (opnd_q == '0);
            end
          endcase
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (res_wr) begin
      zero_d     = (y_d == '0);
      negative_d = y_d[WIDTH-1];
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      y_q        <= '0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      overflow_q <= overflow_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed corner cases,
// backpressure, asynchronous reset mid-operation and randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y;
  logic        overflow, carry, zero, negative;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .overflow(overflow), .carry(carry), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Reference: {y, overflow, carry} from the arithmetic definition of each op.
  function automatic logic [33:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z);
    logic [32:0] w;
    logic [63:0] p;
    logic [31:0] r;
    logic        ov, c;
    int          sh;
    r  = '0;
    ov = 1'b0;
    c  = 1'b0;
    sh = (z >= 32'd32) ? 31 : int'(z[4:0]);
    p  = 64'(x) * 64'(z);
    case (o)
      4'd0: begin
        w  = {1'b0, x} + {1'b0, z};
        r  = w[31:0];
        c  = w[32];
        ov = (x[31] == z[31]) && (r[31] != x[31]);
      end
      4'd1: begin
        r  = x - z;
        c  = (x < z);
        ov = (x[31] != z[31]) && (r[31] != x[31]);
      end
      4'd2: r = x & z;
      4'd3: r = x | z;
      4'd4: r = x ^ z;
      4'd5: r = x << sh;
      4'd6: r = x >> sh;
      4'd7: r = $signed(x) >>> sh;
      4'd8: begin
        r = p[31:0];
        c = (p[63:32] != 64'd0);
      end
      4'd9: r = p[63:32];
      4'd10: begin
        r  = (z == 0) ? 32'hFFFF_FFFF : x / z;
        ov = (z == 0);
      end
      4'd11: begin
        r  = (z == 0) ? x : x % z;
        ov = (z == 0);
      end
      default: r = '0;
    endcase
    return {r, ov, c};
  endfunction

  function automatic int exp_lat(input logic [3:0] o);
    return (o >= 4'd8 && o <= 4'd11) ? 32 : 1;
  endfunction

  // Issue one request, scramble inputs after accept, wait (bounded) for out_valid.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z,
                        output logic [31:0] ry, output logic rov, output logic rc,
                        output logic rz, output logic rn, output int lat, output logic rdy_bad);
    @(negedge clk);
    rdy_bad = !in_ready;
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    ry = y; rov = overflow; rc = carry; rz = zero; rn = negative;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({out_valid, in_ready, y, overflow, carry, zero, negative} !== 38'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b rdy=%b y=%h o=%b c=%b z=%b n=%b, want all 0",
               out_valid, in_ready, y, overflow, carry, zero, negative);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got in_ready=%b want 1", in_ready);
    end
  endtask

  typedef struct {
    logic [3:0]  o;
    logic [31:0] x, z, ey;
    logic        eo, ec;
  } vec_t;

  task automatic test_directed();
    vec_t        v [14];
    logic [31:0] ry;
    logic        rov, rc, rz, rn, rdy_bad;
    int          lat;
    v = '{
      '{4'd0,  32'hFFFF_FFFF, 32'd1,  32'h0000_0000, 1'b0, 1'b1},
      '{4'd1,  32'h8000_0000, 32'd1,  32'h7FFF_FFFF, 1'b1, 1'b0},
      '{4'd1,  32'd1,         32'd2,  32'hFFFF_FFFF, 1'b0, 1'b1},
      '{4'd5,  32'd1,         32'd32, 32'h8000_0000, 1'b0, 1'b0},
      '{4'd6,  32'h8000_0000, 32'd33, 32'h0000_0001, 1'b0, 1'b0},
      '{4'd7,  32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{4'd8,  32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b1},
      '{4'd9,  32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, 1'b0},
      '{4'd10, 32'd100,       32'd7,  32'd14,        1'b0, 1'b0},
      '{4'd11, 32'd100,       32'd7,  32'd2,         1'b0, 1'b0},
      '{4'd10, 32'd5,         32'd0,  32'hFFFF_FFFF, 1'b1, 1'b0},
      '{4'd11, 32'd5,         32'd0,  32'd5,         1'b1, 1'b0},
      '{4'd13, 32'h1234_5678, 32'd9,  32'd0,         1'b0, 1'b0},
      '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0}
    };
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].o, v[i].x, v[i].z, ry, rov, rc, rz, rn, lat, rdy_bad);
      tests++;
      if ({ry, rov, rc, rz, rn, rdy_bad} !== {v[i].ey, v[i].eo, v[i].ec, (v[i].ey == 0), v[i].ey[31], 1'b0}
          || lat != exp_lat(v[i].o)) begin
        fails++;
        $display("FAIL directed[%0d] op=%0d: got y=%h o=%b c=%b z=%b n=%b lat=%0d rdybad=%b, want y=%h o=%b c=%b z=%b n=%b lat=%0d",
                 i, v[i].o, ry, rov, rc, rz, rn, lat, rdy_bad, v[i].ey, v[i].eo, v[i].ec,
                 (v[i].ey == 0), v[i].ey[31], exp_lat(v[i].o));
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ry;
    logic        rov, rc, rz, rn, rdy_bad;
    int          lat;
    run_op(4'd0, 32'd1, 32'd2, ry, rov, rc, rz, rn, lat, rdy_bad);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; op = 4'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || y !== 32'd3 || in_ready !== 1'b0 || zero !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b y=%h rdy=%b z=%b, want valid=1 y=3 rdy=0 z=0",
                 i, out_valid, y, in_ready, zero);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: got valid=%b rdy=%b, want valid=0 rdy=1", out_valid, in_ready);
    end
    run_op(4'd0, 32'd4, 32'd5, ry, rov, rc, rz, rn, lat, rdy_bad);
    tests++;
    if (ry !== 32'd9 || lat != 1 || rdy_bad !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_next: got y=%h lat=%0d rdybad=%b, want y=9 lat=1", ry, lat, rdy_bad);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] ry;
    logic        rov, rc, rz, rn, rdy_bad;
    int          lat;
    @(negedge clk);
    op = 4'd8; a = 32'h1234_5678; b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, y, overflow, carry, zero, negative} !== 38'd0) begin
      fails++;
      $display("FAIL reset_mid_mul: got valid=%b rdy=%b y=%h o=%b c=%b z=%b n=%b, want all 0",
               out_valid, in_ready, y, overflow, carry, zero, negative);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_ready: got in_ready=%b want 1", in_ready);
    end
    run_op(4'd0, 32'd1, 32'd2, ry, rov, rc, rz, rn, lat, rdy_bad);
    tests++;
    if ({ry, rov, rc, rz, rn} !== {32'd3, 4'b0000} || lat != 1 || rdy_bad !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: got y=%h o=%b c=%b z=%b n=%b lat=%0d, want y=3 flags 0 lat=1",
               ry, rov, rc, rz, rn, lat);
    end
    finish_op();
  endtask

  task automatic test_random();
    logic [31:0] ry, x, z, ey;
    logic [33:0] m;
    logic [3:0]  o;
    logic        rov, rc, rz, rn, rdy_bad;
    int          lat;
    for (int i = 0; i < 500; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       z = 32'($urandom_range(0, 40));
        1:       z = 32'd0;
        default: z = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'($urandom_range(0, 3));
      m  = model(o, x, z);
      ey = m[33:2];
      run_op(o, x, z, ry, rov, rc, rz, rn, lat, rdy_bad);
      tests++;
      if ({ry, rov, rc, rz, rn, rdy_bad} !== {ey, m[1], m[0], (ey == 0), ey[31], 1'b0} || lat != exp_lat(o)) begin
        fails++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got y=%h o=%b c=%b z=%b n=%b lat=%0d rdybad=%b, want y=%h o=%b c=%b z=%b n=%b lat=%0d",
                 i, o, x, z, ry, rov, rc, rz, rn, lat, rdy_bad, ey, m[1], m[0], (ey == 0), ey[31], exp_lat(o));
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
